// File: rtl/mem_port_arbiter.sv
// Shares one pipelined memory port between instruction fetch and the datapath, tagging
// in-flight reads so returning data is routed back to the requester that issued them.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned RDATA_W    = 24,
    parameter int unsigned WDATA_W    = 8,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               if_req_i,
    input  logic [ADDR_W-1:0]  if_addr_i,
    output logic               if_gnt_o,
    output logic               if_rvalid_o,
    output logic [RDATA_W-1:0] if_rdata_o,
    input  logic               if_flush_i,
    input  logic               dp_req_i,
    input  logic               dp_we_i,
    input  logic [ADDR_W-1:0]  dp_addr_i,
    input  logic [WDATA_W-1:0] dp_wdata_i,
    output logic               dp_gnt_o,
    output logic               dp_rvalid_o,
    output logic [RDATA_W-1:0] dp_rdata_o,
    output logic [ADDR_W-1:0]  mem_addr_o,
    output logic               mem_we_o,
    output logic [WDATA_W-1:0] mem_wdata_o,
    input  logic [RDATA_W-1:0] mem_rdata_i,
    output logic               busy_o
);
    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    logic [3:0]         starve_q, starve_d;
    logic [MEM_LAT-1:0] vld_q, vld_d;
    logic [MEM_LAT-1:0] own_if_q, own_if_d;
    logic [MEM_LAT-1:0] vld_live;
    logic               push;

    // Datapath wins unless fetch has already lost STARVE_MAX cycles in a row.
    always_comb begin
        if_gnt_o = 1'b0;
        dp_gnt_o = 1'b0;
        if (!rst_i) begin
            if_gnt_o = if_req_i & (~dp_req_i | (starve_q == StarveMax));
            dp_gnt_o = dp_req_i & ~if_gnt_o;
        end
    end

    always_comb begin
        starve_d = 4'd0;
        if (if_req_i && !if_gnt_o) begin
            starve_d = (starve_q == StarveMax) ? starve_q : starve_q + 4'd1;
        end
    end

    always_comb begin
        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_wdata_o = '0;
        if (if_gnt_o) begin
            mem_addr_o = if_addr_i;
        end else if (dp_gnt_o) begin
            mem_addr_o  = dp_addr_i;
            mem_we_o    = dp_we_i;
            mem_wdata_o = dp_wdata_i;
        end
    end

    // Flush kills fetch-owned stages now, including the one being delivered this cycle.
    always_comb begin
        vld_live    = vld_q & ~(own_if_q & {MEM_LAT{if_flush_i}});
        push        = if_gnt_o | (dp_gnt_o & ~dp_we_i);
        vld_d       = '0;
        own_if_d    = '0;
        vld_d[0]    = push & ~(if_gnt_o & if_flush_i);
        own_if_d[0] = if_gnt_o;
        for (int i = 1; i < MEM_LAT; i++) begin
            vld_d[i]    = vld_live[i-1];
            own_if_d[i] = own_if_q[i-1];
        end
    end

    always_comb begin
        if_rvalid_o = ~rst_i & vld_live[MEM_LAT-1] & own_if_q[MEM_LAT-1];
        dp_rvalid_o = ~rst_i & vld_live[MEM_LAT-1] & ~own_if_q[MEM_LAT-1];
        if_rdata_o  = rst_i ? '0 : mem_rdata_i;
        dp_rdata_o  = rst_i ? '0 : mem_rdata_i;
        busy_o      = ~rst_i & (|vld_live);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_q <= 4'd0;
            vld_q    <= '0;
            own_if_q <= '0;
        end else begin
            starve_q <= starve_d;
            vld_q    <= vld_d;
            own_if_q <= own_if_d;
        end
    end

endmodule
